dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit data words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15: extra cycles inserted before each access completes.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  in  1  initiator presents a request.
REQ-007 SHALL have port req_ready  out  1  responder accepts a request.
REQ-008 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data.
REQ-011 SHALL have port req_wstrb  in  4  store byte-lane enables; bit i covers bits 8i+7:8i.
REQ-012 SHALL have port rsp_valid  out  1  response available.
REQ-013 SHALL have port rsp_ready  in  1  initiator consumes the response.
REQ-014 SHALL have port rsp_rdata  out  32  load data.
REQ-015 SHALL have port rsp_err  out  1  access fault (misaligned or out of range).

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-018 SHALL accept a request on the edge where req_valid && req_ready, and on that edge latch addr, wdata, wstrb and write.
REQ-019 SHALL, on accept, go to WAIT with wait counter = WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise go directly to RESP.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-021 SHALL perform the memory access on the edge that enters RESP; rsp_valid therefore rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 SHALL, for a load, capture word[addr[31:2]] into rsp_rdata on that edge.
REQ-023 SHALL, for a store, write only the lanes enabled by wstrb and set rsp_rdata=0; wstrb=0000 is a legal no-op that completes normally.
REQ-024 SHALL raise rsp_err when addr[1:0]!=0 or addr[31:2]>=DEPTH; a faulted access modifies no memory and returns rsp_rdata=0.
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-026 SHALL never accept a new request in the cycle a response is consumed; req_ready rises the cycle after, giving a minimum spacing of WAIT_CYCLES+2 cycles between accepts.
REQ-027 SHALL ignore req_* inputs outside IDLE, and SHALL ignore rsp_ready outside RESP.
REQ-028 SHALL provide read-after-write ordering: a load accepted after a store response has been consumed returns the stored data.

Reset
REQ-029 SHALL, on rst_n=0, immediately force state=IDLE, counter=0, req_ready=1 (after release, in IDLE), rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-030 SHALL abort any in-flight request when reset is asserted mid-operation; a store still in WAIT is not committed.
REQ-031 SHALL not reset the memory array; its contents persist across reset.

Structure
REQ-032 SHALL place the FSM state encoding, the strobe width (4) and the WAIT_CYCLES counter width (4) in shared package dmem_bus_pkg.
REQ-033 SHALL isolate storage in sub-module dmem_bank: a DEPTH x 32 array with a byte-lane write enable and a synchronous read port.

Verification
REQ-034 SHALL test the following, with WAIT_CYCLES=1: store addr 0x10, wdata 0xDEADBEEF, wstrb 1111, then load 0x10 -> rdata 0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
REQ-035 SHALL test a partial store: store 0x10, wdata 0x000000AA, wstrb 0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-036 SHALL test a misaligned load at 0x13 -> rsp_err=1, rdata=0; an out-of-range store at 0x400 (DEPTH=256) -> rsp_err=1, and a later load of word 0 is unchanged.
REQ-037 SHALL test backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout, req_ready=1 the cycle after consume.
REQ-038 SHALL test reset mid-WAIT (WAIT_CYCLES=3) during store 0x20 = 0x12345678 -> outputs cleared asynchronously, and a later load of 0x20 returns the old value.
REQ-039 SHALL test WAIT_CYCLES=0 with back-to-back requests and rsp_ready=1 -> rsp_valid 1 cycle after accept, accepts spaced 2 cycles apart.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared types and widths for the data-memory responder and its storage bank.
package dmem_bus_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned word access, or word index beyond the populated depth.
  function automatic logic access_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 word storage with byte-lane writes and a registered read port.
module dmem_bank
  import dmem_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     idx,
  input  logic [STRB_W-1:0] wr_lanes,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              rd_zero,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself is never reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (wr_lanes[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a programmable wait window.
//   state   | meaning
//   IDLE    | req_ready high, waiting for a request
//   WAIT    | request latched, counting down the wait window
//   RESP    | access done, response held until rsp_ready
module dmem_responder
  import dmem_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [STRB_W-1:0] lat_wstrb;
  logic              lat_write;

  logic              accept;
  logic              enter_resp;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [STRB_W-1:0] acc_wstrb;
  logic              acc_write;
  logic              acc_fault;
  logic [AW-1:0]     idx;
  logic [STRB_W-1:0] wr_lanes;
  logic              rd_en;
  logic              rd_zero;

  // With no wait window the access happens on the accept edge, so it must
  // use the live request rather than the not-yet-latched copy.
  always_comb begin
    accept     = (state == ST_IDLE) && req_valid;
    enter_resp = (WAIT_CYCLES == 0) ? accept : ((state == ST_WAIT) && (cnt == '0));
    if (state == ST_IDLE) begin
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
      acc_write = req_write;
    end else begin
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
      acc_write = lat_write;
    end
    acc_fault = access_fault(acc_addr, DEPTH);
    idx       = acc_addr[AW+1:2];
    wr_lanes  = (enter_resp && acc_write && !acc_fault) ? acc_wstrb : '0;
    rd_en     = enter_resp;
    rd_zero   = acc_write || acc_fault;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      lat_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            lat_write <= req_write;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= acc_fault;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_fault;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  dmem_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .wr_lanes (wr_lanes),
    .wdata    (acc_wdata),
    .rd_en    (rd_en),
    .rd_zero  (rd_zero),
    .rd_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 1, 3 and 0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];
  logic [3:0]  req_wstrb [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wstrb(req_wstrb[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[$];
  vec_t bt[4];

  function automatic vec_t mk(int d, logic wr, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] s, logic [31:0] er, logic ee, int el);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = a; v.wdata = wd; v.strb = s;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic issue(int d, logic wr, logic [31:0] a, logic [31:0] wd, logic [3:0] s);
    @(negedge clk);
    req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd; req_wstrb[d] = s;
    req_valid[d] = 1'b1;
    for (int i = 0; i < 20 && !req_ready[d]; i++) @(negedge clk);
    chk("issue_ready", req_ready[d], 1);
  endtask

  task automatic wait_rsp(int d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid[d] = 1'b0;
      lat++;
    end while (!rsp_valid[d] && lat < 40);
  endtask

  task automatic consume(int d);
    chk("ready_low_in_resp", req_ready[d], 0);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("ready_after_consume", req_ready[d], 1);
    chk("valid_after_consume", rsp_valid[d], 0);
  endtask

  task automatic run_vec(vec_t v);
    int lat;
    issue(v.d, v.wr, v.addr, v.wdata, v.strb);
    wait_rsp(v.d, lat);
    chk($sformatf("lat d%0d a=%h", v.d, v.addr), lat, v.exp_lat);
    chk($sformatf("rdata d%0d a=%h", v.d, v.addr), rsp_rdata[v.d], v.exp_rdata);
    chk($sformatf("err d%0d a=%h", v.d, v.addr), rsp_err[v.d], v.exp_err);
    consume(v.d);
  endtask

  initial begin
    int lat;
    rst_n = 3'b000; req_valid = '0; req_write = '0; rsp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
    end

    // WAIT_CYCLES=1 instance
    vt.push_back(mk(0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        0, 2));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0, 2));
    vt.push_back(mk(0, 1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        0, 2));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 0, 2));
    vt.push_back(mk(0, 1, 32'h0,   32'h11223344, 4'hF, 32'h0,        0, 2));
    vt.push_back(mk(0, 0, 32'h0,   32'h0,        4'h0, 32'h11223344, 0, 2));
    vt.push_back(mk(0, 0, 32'h13,  32'h0,        4'h0, 32'h0,        1, 2));
    vt.push_back(mk(0, 1, 32'h400, 32'hAAAAAAAA, 4'hF, 32'h0,        1, 2));
    vt.push_back(mk(0, 0, 32'h0,   32'h0,        4'h0, 32'h11223344, 0, 2));
    vt.push_back(mk(0, 1, 32'h3FC, 32'h01020304, 4'hF, 32'h0,        0, 2));
    vt.push_back(mk(0, 1, 32'h3FC, 32'hFFFFFFFF, 4'hA, 32'h0,        0, 2));
    vt.push_back(mk(0, 0, 32'h3FC, 32'h0,        4'h0, 32'hFF02FF04, 0, 2));
    vt.push_back(mk(0, 1, 32'h3FC, 32'h55555555, 4'h0, 32'h0,        0, 2));
    vt.push_back(mk(0, 0, 32'h3FC, 32'h0,        4'h0, 32'hFF02FF04, 0, 2));
    vt.push_back(mk(0, 1, 32'h12,  32'h99999999, 4'hF, 32'h0,        1, 2));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 0, 2));
    // WAIT_CYCLES=0 instance
    vt.push_back(mk(2, 1, 32'h4,   32'h0BADF00D, 4'hF, 32'h0,        0, 1));
    vt.push_back(mk(2, 0, 32'h4,   32'h0,        4'h0, 32'h0BADF00D, 0, 1));
    vt.push_back(mk(2, 0, 32'h6,   32'h0,        4'h0, 32'h0,        1, 1));

    bt[0] = mk(2, 1, 32'h8, 32'h55AA55AA, 4'hF, 32'h0,        0, 1);
    bt[1] = mk(2, 0, 32'h8, 32'h0,        4'h0, 32'h55AA55AA, 0, 1);
    bt[2] = mk(2, 1, 32'h8, 32'h000000FF, 4'h3, 32'h0,        0, 1);
    bt[3] = mk(2, 0, 32'h8, 32'h0,        4'h0, 32'h55AA00FF, 0, 1);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready d%0d", i), req_ready[i], 1);
      chk($sformatf("reset_valid d%0d", i), rsp_valid[i], 0);
      chk($sformatf("reset_rdata d%0d", i), rsp_rdata[i], 0);
      chk($sformatf("reset_err d%0d", i), rsp_err[i], 0);
    end
    rst_n = 3'b111;

    foreach (vt[i]) run_vec(vt[i]);

    // Backpressure: response held while a competing request is presented.
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    wait_rsp(0, lat);
    chk("bp_lat", lat, 2);
    req_write[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0; req_wstrb[0] = 4'hF;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid[0], 1);
      chk("bp_rdata", rsp_rdata[0], 32'hDEADBEAA);
      chk("bp_ready", req_ready[0], 0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    chk("bp_valid_end", rsp_valid[0], 1);
    consume(0);
    run_vec(mk(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0, 2));

    // Reset in the middle of the WAIT window of a store.
    run_vec(mk(1, 1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0,        0, 4));
    run_vec(mk(1, 0, 32'h20, 32'h0,        4'h0, 32'hA5A5A5A5, 0, 4));
    issue(1, 1, 32'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rst_pre_valid", rsp_valid[1], 0);
    chk("rst_pre_ready", req_ready[1], 0);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("rst_async_valid", rsp_valid[1], 0);
    chk("rst_async_rdata", rsp_rdata[1], 0);
    chk("rst_async_err", rsp_err[1], 0);
    chk("rst_async_ready", req_ready[1], 1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_post_valid", rsp_valid[1], 0);
    chk("rst_post_ready", req_ready[1], 1);
    run_vec(mk(1, 0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 4));

    // Back-to-back requests with rsp_ready held high on the zero-wait instance.
    begin
      int k = 0, cur = -1, acc_c = -1, done = 0;
      bit pend = 0;
      @(negedge clk);
      rsp_ready[2] = 1'b1;
      req_write[2] = bt[0].wr; req_addr[2] = bt[0].addr;
      req_wdata[2] = bt[0].wdata; req_wstrb[2] = bt[0].strb;
      req_valid[2] = 1'b1;
      for (int c = 0; c < 30 && done < 4; c++) begin
        if (rsp_valid[2] && cur >= 0) begin
          chk("b2b_lat", c - acc_c, 1);
          chk("b2b_rdata", rsp_rdata[2], bt[cur].exp_rdata);
          chk("b2b_err", rsp_err[2], bt[cur].exp_err);
          done++;
          cur = -1;
        end
        if (pend) begin
          pend = 0;
          if (k < 4) begin
            req_write[2] = bt[k].wr; req_addr[2] = bt[k].addr;
            req_wdata[2] = bt[k].wdata; req_wstrb[2] = bt[k].strb;
          end else begin
            req_valid[2] = 1'b0;
          end
        end
        if (req_valid[2] && req_ready[2]) begin
          if (acc_c >= 0) chk("b2b_spacing", c - acc_c, 2);
          acc_c = c;
          cur = k;
          k++;
          pend = 1;
        end
        @(negedge clk);
      end
      req_valid[2] = 1'b0;
      rsp_ready[2] = 1'b0;
      chk("b2b_done", done, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
